// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch unit and its PC register.
//   - fetch_state_t : fetch controller states (IDLE, REQ, WAIT, HOLD)
//   - ADDR_W_DEF    : default word-address width
//   - DATA_W_DEF    : default instruction width
//   - RESET_PC_DEF  : default fetch address after reset
package fetch_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // just out of reset
        REQ  = 2'd1,   // request presented to instruction memory
        WAIT = 2'd2,   // one request outstanding, waiting for read data
        HOLD = 2'd3    // instruction presented to decode
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: fetch program counter.
//   clk      : clock
//   reset    : synchronous, active-low; loads RESET_PC
//   load     : take load_val (redirect); wins over inc
//   load_val : redirect target
//   inc      : advance by one word, wrapping modulo 2^ADDR_W
//   pc       : current fetch PC
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_reg <= RESET_PC;
        end else if (load) begin
            pc_reg <= load_val;
        end else if (inc) begin
            pc_reg <= pc_reg + ADDR_W'(1);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one instruction at a time from instruction memory
// and hands it to decode, absorbing branch/jump redirects.
//   clk, reset             : clock, synchronous active-low reset
//   imem_req/imem_addr     : request to instruction memory (held until imem_gnt)
//   imem_gnt               : memory accepted the request
//   imem_rvalid/imem_rdata : read response, at least one cycle after the grant
//   redirect/redirect_pc   : taken branch/jump and its target
//   if_valid/id_ready      : handshake towards decode
//   if_instr/if_pc/if_npc  : instruction, its address and the sequential next address
//   pc                     : current fetch PC
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_npc,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state_reg, state_next;
    logic              drop_reg, drop_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
    logic              valid_reg, valid_next;
    logic [DATA_W-1:0] instr_reg, instr_next;
    logic [ADDR_W-1:0] if_pc_reg, if_pc_next;
    logic [ADDR_W-1:0] if_npc_reg, if_npc_next;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_cur;
    logic [ADDR_W-1:0] pc_target;

    // Every redirect loads the PC regardless of state; the register gives
    // load priority over the increment, so the latest redirect always wins.
    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (redirect),
        .load_val (redirect_pc),
        .inc      (pc_inc),
        .pc       (pc_cur)
    );

    // Address for a request that starts next cycle: a same-cycle redirect
    // overrides the stored PC.
    assign pc_target = redirect ? redirect_pc : pc_cur;

    always_comb begin
        state_next  = state_reg;
        drop_next   = drop_reg;
        addr_next   = addr_reg;
        req_pc_next = req_pc_reg;
        valid_next  = valid_reg;
        instr_next  = instr_reg;
        if_pc_next  = if_pc_reg;
        if_npc_next = if_npc_reg;
        pc_inc      = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = REQ;
                addr_next  = pc_target;
            end
            REQ: begin
                // The request in flight (addr_reg) is never changed before the
                // grant; a redirect only marks its response as stale.
                if (redirect) begin
                    drop_next = 1'b1;
                end
                if (imem_gnt) begin
                    req_pc_next = addr_reg;
                    // A stale request must not advance the PC: it already
                    // holds the redirect target for the next request.
                    pc_inc      = !drop_reg;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (!drop_reg && !redirect) begin
                        instr_next  = imem_rdata;
                        if_pc_next  = req_pc_reg;
                        if_npc_next = req_pc_reg + ADDR_W'(1);
                        valid_next  = 1'b1;
                        state_next  = HOLD;
                    end else begin
                        drop_next  = 1'b0;
                        addr_next  = pc_target;
                        state_next = REQ;
                    end
                end else if (redirect) begin
                    drop_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || id_ready) begin
                    valid_next = 1'b0;
                    addr_next  = pc_target;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            drop_reg   <= 1'b0;
            addr_reg   <= '0;
            req_pc_reg <= '0;
            valid_reg  <= 1'b0;
            instr_reg  <= '0;
            if_pc_reg  <= '0;
            if_npc_reg <= '0;
        end else begin
            state_reg  <= state_next;
            drop_reg   <= drop_next;
            addr_reg   <= addr_next;
            req_pc_reg <= req_pc_next;
            valid_reg  <= valid_next;
            instr_reg  <= instr_next;
            if_pc_reg  <= if_pc_next;
            if_npc_reg <= if_npc_next;
        end
    end

    assign imem_req  = (state_reg == REQ);
    assign imem_addr = addr_reg;
    assign if_valid  = valid_reg;
    assign if_instr  = instr_reg;
    assign if_pc     = if_pc_reg;
    assign if_npc    = if_npc_reg;
    assign pc        = pc_cur;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench for instr_fetch_unit. A memory model
// answers requests with random grant/latency; a program-order reference model
// (next address = previous + 1, or the latest redirect target) pushes expected
// PCs into a queue which a negedge monitor pops whenever decode is presented
// a new instruction.
module tb_instr_fetch_unit;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_npc;
    logic          id_ready = 1'b0;
    logic [AW-1:0] pc;

    instr_fetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (10'h000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_npc      (if_npc),
        .id_ready    (id_ready),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int deliveries = 0;

    logic [DW-1:0] mem_data [1024];
    logic [AW-1:0] exp_q [$];

    // memory behaviour knobs
    int gnt_pct = 70;
    int lat_max = 3;
    bit fast_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instruction memory model ----------------
    bit            pend = 1'b0;
    int            lat = 0;
    logic [AW-1:0] pend_addr = '0;

    always begin
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        if (pend) begin
            lat--;
            if (lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data[pend_addr];
                pend        = 1'b0;
            end
        end
        if (!reset) begin
            // stray responses while in reset must be ignored
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else if (imem_req && !pend && ($urandom_range(99) < gnt_pct)) begin
            imem_gnt  = 1'b1;
            pend      = 1'b1;
            pend_addr = imem_addr;
            lat       = $urandom_range(lat_max, 1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit            held = 1'b0;
    logic [AW-1:0] cur_pc = '0;
    int            idle_cnt = 0;
    bit            req_pending = 1'b0;
    logic [AW-1:0] req_addr_seen = '0;
    int            cyc = 0;
    int            last_pres_cyc = 0;
    bit            last_fast = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            held        = 1'b0;
            idle_cnt    = 0;
            req_pending = 1'b0;
            last_fast   = 1'b0;
        end else begin
            if (req_pending) begin
                check("req_held", {31'd0, imem_req}, 32'd1);
                check("addr_held", {22'd0, imem_addr}, {22'd0, req_addr_seen});
            end
            req_pending   = imem_req && !imem_gnt;
            req_addr_seen = imem_addr;

            if (if_valid) begin
                check("req_low_in_hold", {31'd0, imem_req}, 32'd0);
                idle_cnt = 0;
                if (!held) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_present: got if_pc %0h expected no instruction", if_pc);
                    end else begin
                        cur_pc = exp_q.pop_front();
                        deliveries++;
                        if (fast_mode && last_fast)
                            check("throughput_gap", cyc - last_pres_cyc, 32'd3);
                        last_pres_cyc = cyc;
                        last_fast     = fast_mode;
                    end
                    held = 1'b1;
                end
                check("if_pc", {22'd0, if_pc}, {22'd0, cur_pc});
                check("if_instr", if_instr, mem_data[cur_pc]);
                check("if_npc", {22'd0, if_npc}, {22'd0, cur_pc + 10'd1});
            end else begin
                held = 1'b0;
                idle_cnt++;
                if (idle_cnt > 300) begin
                    checks++;
                    failures++;
                    $display("FAIL progress_timeout: got %0d idle cycles expected at most 300", idle_cnt);
                    idle_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    logic [AW-1:0] model_last = '0;
    bit            r_prev = 1'b0;
    bit            d_prev = 1'b0;
    bit            v_prev = 1'b0;
    logic [AW-1:0] tgt_prev = '0;

    task automatic model_restart();
        exp_q.delete();
        exp_q.push_back(10'h000);
        model_last = 10'h000;
        r_prev = 1'b0;
        d_prev = 1'b0;
        v_prev = 1'b0;
    endtask

    task automatic pick_target(output logic [AW-1:0] t);
        case ($urandom_range(3))
            0: t = 10'h3F0;
            1: t = 10'h3FF;
            2: t = 10'h100;
            default: t = AW'($urandom);
        endcase
    endtask

    task automatic run_cycles(input int n, input int redir_pct, input int ready_pct);
        logic [AW-1:0] tgt;
        bit r;
        bit d;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            // effect of the inputs that were sampled at this edge
            if (r_prev) begin
                exp_q.delete();
                exp_q.push_back(tgt_prev);
                model_last = tgt_prev;
            end else if (v_prev && d_prev) begin
                model_last = model_last + 10'd1;
                exp_q.push_back(model_last);
            end
            v_prev = if_valid;
            r = ($urandom_range(99) < redir_pct);
            d = ($urandom_range(99) < ready_pct);
            pick_target(tgt);
            redirect    = r;
            redirect_pc = r ? tgt : AW'($urandom);
            id_ready    = d;
            r_prev   = r;
            d_prev   = d;
            tgt_prev = tgt;
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++)
            mem_data[a] = 32'hA000_0000 | ($urandom & 32'h003F_FC00) | a;

        // reset held for 3 cycles with stray rvalid
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", {22'd0, pc}, 32'd0);
        check("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_npc", {22'd0, if_npc}, 32'd0);

        @(posedge clk);
        #1;
        model_restart();
        reset = 1'b1;
        @(negedge clk);
        check("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", {22'd0, imem_addr}, 32'd0);

        // steady state: immediate grant, 1-cycle memory, decode always ready
        gnt_pct = 100; lat_max = 1; fast_mode = 1'b1;
        run_cycles(60, 0, 100);
        fast_mode = 1'b0;

        // decode back-pressure, no redirects
        gnt_pct = 70; lat_max = 3;
        run_cycles(150, 0, 30);

        // mixed traffic with redirects
        run_cycles(2500, 6, 70);

        // reset in the middle of operation
        @(posedge clk);
        #1;
        reset = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_imem_req", {31'd0, imem_req}, 32'd0);
        check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
        check("midrst_pc", {22'd0, pc}, 32'd0);
        @(posedge clk);
        #1;
        model_restart();
        reset = 1'b1;
        run_cycles(600, 6, 70);
        run_cycles(40, 0, 100);

        check("deliveries_enough", {31'd0, deliveries > 200}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
